cluster_sequencer: RTL

Iterative cluster-extraction controller wrapped around the 768-pad priority encoder. Each frame it loads the pad valid vector into a working mask and repeatedly presents that mask to the encoder. It takes the highest-priority (lowest-index) found cluster, clears that pad from the mask, and repeats until the mask is empty or MXCLUSTERS clusters have been emitted. It sits between the per-pad cluster-finding logic and the cluster packer/serializer, turning one encoder instance into an ordered stream of up to MXCLUSTERS clusters per frame.

---
 rtl/cluster_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cluster_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cluster_sequencer
//  Description : Iterative cluster-extraction controller around the pad
//                priority encoder. Each frame it loads the pad valid vector
//                into a working mask, presents the mask to the encoder,
//                emits the lowest-index cluster, clears that pad and repeats
//                until the mask is empty or MXCLUSTERS clusters are emitted.
//  Revision    : 1.0 - initial release
// ============================================================================
module cluster_sequencer #(
   parameter int MXPADS      = 768,
   parameter int MXCLUSTERS  = 8,
   parameter int ENC_LATENCY = 1
) (
   input  logic              clock,
   input  logic              global_reset,
   input  logic              start,
   input  logic [MXPADS-1:0] vpfs_in,
   output logic [MXPADS-1:0] enc_vpfs,
   output logic              enc_latch,
   input  logic              enc_found,
   input  logic [10:0]       enc_adr,
   input  logic [2:0]        enc_cnt,
   output logic              clust_valid,
   output logic [10:0]       clust_adr,
   output logic [2:0]        clust_cnt,
   output logic [3:0]        clust_idx,
   output logic              done,
   output logic [3:0]        nclusters,
   output logic              overflow,
   output logic              adr_err,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EVAL = 2'd2
   } state_t;

   localparam logic [3:0]  c_max_clusters = 4'(MXCLUSTERS);
   localparam logic [1:0]  c_enc_latency  = 2'(ENC_LATENCY);
   localparam logic [10:0] c_mxpads       = 11'(MXPADS);

   state_t            state_q, state_d;
   logic [MXPADS-1:0] mask_q, mask_d;
   logic [1:0]        wcnt_q, wcnt_d;
   logic [3:0]        count_q, count_d;
   logic              enc_latch_q, enc_latch_d;
   logic              clust_valid_q, clust_valid_d;
   logic [10:0]       clust_adr_q, clust_adr_d;
   logic [2:0]        clust_cnt_q, clust_cnt_d;
   logic [3:0]        clust_idx_q, clust_idx_d;
   logic              done_q, done_d;
   logic [3:0]        nclusters_q, nclusters_d;
   logic              overflow_q, overflow_d;
   logic              adr_err_q, adr_err_d;
   logic              busy_q, busy_d;

   logic [MXPADS-1:0] adr_onehot;
   logic [MXPADS-1:0] mask_cleared;
   logic [3:0]        count_inc;
   logic              adr_bad;

   // Mask with the encoder-reported pad removed, plus address sanity check
   always_comb begin
      adr_onehot   = {{(MXPADS-1){1'b0}}, 1'b1} << enc_adr;
      mask_cleared = mask_q & ~adr_onehot;
      count_inc    = count_q + 4'd1;
      adr_bad      = (enc_adr >= c_mxpads);
   end

   // Next-state and registered-output computation for the frame sequencer
   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      wcnt_d        = wcnt_q;
      count_d       = count_q;
      enc_latch_d   = 1'b0;
      clust_valid_d = 1'b0;
      clust_adr_d   = clust_adr_q;
      clust_cnt_d   = clust_cnt_q;
      clust_idx_d   = clust_idx_q;
      done_d        = 1'b0;
      nclusters_d   = nclusters_q;
      overflow_d    = overflow_q;
      adr_err_d     = adr_err_q;

      if (start) begin
         // A start mid-frame truncates the running frame; its EVAL result
         // (if any) is discarded and the new frame loads on the same edge.
         if (state_q != ST_IDLE) begin
            done_d      = 1'b1;
            nclusters_d = count_q;
            overflow_d  = 1'b1;
            adr_err_d   = 1'b0;
         end
         mask_d      = vpfs_in;
         enc_latch_d = 1'b1;
         wcnt_d      = c_enc_latency;
         count_d     = 4'd0;
         state_d     = ST_WAIT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_WAIT: begin
               // Let the mask propagate through the encoder pipeline
               if (wcnt_q == 2'd0) begin
                  state_d = ST_EVAL;
               end else begin
                  wcnt_d = wcnt_q - 2'd1;
               end
            end
            ST_EVAL: begin
               if (!enc_found) begin
                  done_d      = 1'b1;
                  nclusters_d = count_q;
                  overflow_d  = 1'b0;
                  adr_err_d   = 1'b0;
                  state_d     = ST_IDLE;
               end else if (adr_bad) begin
                  // Out-of-range address: cannot clear it, so stop the frame
                  done_d      = 1'b1;
                  nclusters_d = count_q;
                  overflow_d  = 1'b0;
                  adr_err_d   = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  clust_valid_d = 1'b1;
                  clust_adr_d   = enc_adr;
                  clust_cnt_d   = enc_cnt;
                  clust_idx_d   = count_q;
                  mask_d        = mask_cleared;
                  count_d       = count_inc;
                  if (count_inc == c_max_clusters) begin
                     done_d      = 1'b1;
                     nclusters_d = count_inc;
                     overflow_d  = |mask_cleared;
                     adr_err_d   = 1'b0;
                     state_d     = ST_IDLE;
                  end else begin
                     wcnt_d  = c_enc_latency;
                     state_d = ST_WAIT;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (global_reset) begin
         state_q       <= ST_IDLE;
         mask_q        <= '0;
         wcnt_q        <= 2'd0;
         count_q       <= 4'd0;
         enc_latch_q   <= 1'b0;
         clust_valid_q <= 1'b0;
         clust_adr_q   <= 11'd0;
         clust_cnt_q   <= 3'd0;
         clust_idx_q   <= 4'd0;
         done_q        <= 1'b0;
         nclusters_q   <= 4'd0;
         overflow_q    <= 1'b0;
         adr_err_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mask_q        <= mask_d;
         wcnt_q        <= wcnt_d;
         count_q       <= count_d;
         enc_latch_q   <= enc_latch_d;
         clust_valid_q <= clust_valid_d;
         clust_adr_q   <= clust_adr_d;
         clust_cnt_q   <= clust_cnt_d;
         clust_idx_q   <= clust_idx_d;
         done_q        <= done_d;
         nclusters_q   <= nclusters_d;
         overflow_q    <= overflow_d;
         adr_err_q     <= adr_err_d;
         busy_q        <= busy_d;
      end
   end

   assign enc_vpfs    = mask_q;
   assign enc_latch   = enc_latch_q;
   assign clust_valid = clust_valid_q;
   assign clust_adr   = clust_adr_q;
   assign clust_cnt   = clust_cnt_q;
   assign clust_idx   = clust_idx_q;
   assign done        = done_q;
   assign nclusters   = nclusters_q;
   assign overflow    = overflow_q;
   assign adr_err     = adr_err_q;
   assign busy        = busy_q;

endmodule
`default_nettype wire
